fu_mul_pipe: RTL and testbench

- Fully pipelined integer multiply functional unit for the INTM reservation station path.
- Accepts one MUL/MULH/MULHSU/MULHU uop per cycle, with STAGES-cycle latency and per-stage valid/backpressure.
- Delivers a registered result packet to the CDB arbiter via valid/ready.
- Successor to the single-in-flight sequential multiplier: parametrised width, depth and tag widths; multiple ops in flight; bubble collapsing under stall.

---
 rtl/fu_mul_pipe.sv | 150 +++++++++++++++
 tb/tb_fu_mul_pipe.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_mul_pipe.sv
// Pipelined integer multiply unit (MUL/MULH/MULHSU/MULHU) with per-slot
// valid/backpressure and bubble collapsing. Feeds the CDB arbiter.
//
// Ports:
//   clk, rst_n (async active-low), flush (sync kill of all in-flight ops)
//   in_valid/in_ready, in_op, in_rs1, in_rs2, in_rob_id, in_rd_phy,
//   in_rd_arch : uop issue side
//   out_valid/out_ready, out_rob_id, out_rd_phy, out_rd_arch, out_value :
//   result side, driven from the last slot
//   out_rs1_dbg, out_rs2_dbg : operand echo, only with FU_MUL_DBG_EN
//
// Optional feature macro: FU_MUL_DBG_EN
module fu_mul_pipe #(
    parameter int XLEN       = 32,
    parameter int STAGES     = 3,
    parameter int ROB_IDX_W  = 5,
    parameter int PRF_IDX_W  = 6,
    parameter int ARCH_IDX_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic [XLEN-1:0]       in_rs1,
    input  logic [XLEN-1:0]       in_rs2,
    input  logic [ROB_IDX_W-1:0]  in_rob_id,
    input  logic [PRF_IDX_W-1:0]  in_rd_phy,
    input  logic [ARCH_IDX_W-1:0] in_rd_arch,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ROB_IDX_W-1:0]  out_rob_id,
    output logic [PRF_IDX_W-1:0]  out_rd_phy,
    output logic [ARCH_IDX_W-1:0] out_rd_arch,
    output logic [XLEN-1:0]       out_value
`ifdef FU_MUL_DBG_EN
    ,
    output logic [XLEN-1:0]       out_rs1_dbg,
    output logic [XLEN-1:0]       out_rs2_dbg
`endif
);

    typedef struct packed {
        logic [ROB_IDX_W-1:0]  rob_id;
        logic [PRF_IDX_W-1:0]  rd_phy;
        logic [ARCH_IDX_W-1:0] rd_arch;
        logic [XLEN-1:0]       value;
`ifdef FU_MUL_DBG_EN
        logic [XLEN-1:0]       rs1;
        logic [XLEN-1:0]       rs2;
`endif
    } slot_t;

    logic [STAGES-1:0] r_vld;
    slot_t [STAGES-1:0] r_slot;

    logic              w_sgn1;
    logic              w_sgn2;
    logic [XLEN:0]     w_a;
    logic [XLEN:0]     w_b;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_res;
    slot_t             w_in_slot;

    logic [STAGES-1:0] w_free;
    logic [STAGES-1:0] w_src_vld;
    slot_t [STAGES-1:0] w_src;

    // MULHU zero-extends both operands; MULHSU only rs2.
    assign w_sgn1 = (in_op != 2'b11);
    assign w_sgn2 = !in_op[1];
    assign w_a = {w_sgn1 & in_rs1[XLEN-1], in_rs1};
    assign w_b = {w_sgn2 & in_rs2[XLEN-1], in_rs2};

    // Sign-extended operands multiplied modulo 2^(2*XLEN) give the exact
    // low 2*XLEN bits of the signed (XLEN+1)x(XLEN+1) product.
    assign w_prod = {{(XLEN-1){w_a[XLEN]}}, w_a}
                  * {{(XLEN-1){w_b[XLEN]}}, w_b};

    assign w_res = (in_op == 2'b00) ? w_prod[XLEN-1:0]
                                    : w_prod[2*XLEN-1:XLEN];

    always_comb begin
        w_in_slot         = '0;
        w_in_slot.rob_id  = in_rob_id;
        w_in_slot.rd_phy  = in_rd_phy;
        w_in_slot.rd_arch = in_rd_arch;
        w_in_slot.value   = w_res;
`ifdef FU_MUL_DBG_EN
        w_in_slot.rs1     = in_rs1;
        w_in_slot.rs2     = in_rs2;
`endif
    end

    // Slot k frees when any slot from k to the end is empty, or the
    // output is being taken: that is the recursive advance rule unrolled.
    always_comb begin
        logic w_full_run;
        w_free     = '0;
        w_full_run = 1'b1;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_full_run = w_full_run & r_vld[k];
            w_free[k]  = out_ready | ~w_full_run;
        end
    end

    always_comb begin
        w_src_vld    = '0;
        w_src        = '0;
        w_src_vld[0] = in_valid;
        w_src[0]     = w_in_slot;
        for (int k = 1; k < STAGES; k++) begin
            w_src_vld[k] = r_vld[k-1];
            w_src[k]     = r_slot[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_slot <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (flush) begin
                    r_vld[k] <= 1'b0;
                end else if (w_free[k]) begin
                    r_vld[k] <= w_src_vld[k];
                end
                // Payload only moves with a valid source, so a stalled
                // or drained slot keeps its last contents.
                if (!flush && w_free[k] && w_src_vld[k]) begin
                    r_slot[k] <= w_src[k];
                end
            end
        end
    end

    assign in_ready    = w_free[0];
    assign out_valid   = r_vld[STAGES-1];
    assign out_rob_id  = r_slot[STAGES-1].rob_id;
    assign out_rd_phy  = r_slot[STAGES-1].rd_phy;
    assign out_rd_arch = r_slot[STAGES-1].rd_arch;
    assign out_value   = r_slot[STAGES-1].value;
`ifdef FU_MUL_DBG_EN
    assign out_rs1_dbg = r_slot[STAGES-1].rs1;
    assign out_rs2_dbg = r_slot[STAGES-1].rs2;
`endif

endmodule

// File: tb/tb_fu_mul_pipe.sv
// Directed bench for fu_mul_pipe at STAGES=3: latency, arithmetic,
// backpressure, bubble collapse, flush and async reset.
module tb_fu_mul_pipe;

    localparam int S = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_rob_id;
    logic [5:0]  in_rd_phy;
    logic [4:0]  in_rd_arch;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rob_id;
    logic [5:0]  out_rd_phy;
    logic [4:0]  out_rd_arch;
    logic [31:0] out_value;
`ifdef FU_MUL_DBG_EN
    logic [31:0] out_rs1_dbg;
    logic [31:0] out_rs2_dbg;
`endif

    int n_cmp = 0;
    int n_err = 0;

    fu_mul_pipe #(
        .XLEN(32), .STAGES(S), .ROB_IDX_W(5),
        .PRF_IDX_W(6), .ARCH_IDX_W(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rob_id(in_rob_id),
        .in_rd_phy(in_rd_phy), .in_rd_arch(in_rd_arch),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rob_id(out_rob_id), .out_rd_phy(out_rd_phy),
        .out_rd_arch(out_rd_arch), .out_value(out_value)
`ifdef FU_MUL_DBG_EN
        ,
        .out_rs1_dbg(out_rs1_dbg), .out_rs2_dbg(out_rs2_dbg)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rob);
        in_valid   = 1'b1;
        in_op      = op;
        in_rs1     = a;
        in_rs2     = b;
        in_rob_id  = rob;
        in_rd_phy  = {1'b1, rob};
        in_rd_arch = ~rob;
    endtask

    // Counts edges from the accepting edge until out_valid, bounded.
    task automatic wait_lat(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int acc;
        int exp_rob;
        int nv;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00;
        in_rs1 = '0; in_rs2 = '0; in_rob_id = '0; in_rd_phy = '0;
        in_rd_arch = '0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_value", out_value, 0);
        chk("rst_out_rob", out_rob_id, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", in_ready, 1);

        // Single MUL, latency and tag echo
        put(2'b00, 32'd7, 32'hFFFF_FFFD, 5'd3);
        chk("t1_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        wait_lat(lat);
        chk("t1_latency", lat, S);
        chk("t1_value", out_value, 32'hFFFF_FFEB);
        chk("t1_rob", out_rob_id, 5'd3);
        chk("t1_phy", out_rd_phy, 6'h23);
        chk("t1_arch", out_rd_arch, 5'h1C);
`ifdef FU_MUL_DBG_EN
        chk("t1_rs1_dbg", out_rs1_dbg, 32'd7);
        chk("t1_rs2_dbg", out_rs2_dbg, 32'hFFFF_FFFD);
`endif
        step();
        chk("t1_drained", out_valid, 0);

        // Back-to-back high-half variants
        put(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd4);
        step();
        put(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
        step();
        put(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
        step();
        in_valid = 1'b0;
        wait_lat(lat);
        chk("t2_rob_a", out_rob_id, 5'd4);
        chk("t2_mulh", out_value, 32'h4000_0000);
`ifdef FU_MUL_DBG_EN
        chk("t2_rs1_dbg", out_rs1_dbg, 32'h8000_0000);
`endif
        step();
        chk("t2_valid_b", out_valid, 1);
        chk("t2_rob_b", out_rob_id, 5'd5);
        chk("t2_mulhsu", out_value, 32'hFFFF_FFFF);
        step();
        chk("t2_valid_c", out_valid, 1);
        chk("t2_rob_c", out_rob_id, 5'd6);
        chk("t2_mulhu", out_value, 32'hFFFF_FFFE);
        step();
        chk("t2_drained", out_valid, 0);

        // Stream under 5-cycle stall
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            put(2'b00, 32'(10 + c), 32'd5, 5'(10 + c));
            chk("t3_in_ready", in_ready, (c < S) ? 1 : 0);
            if (in_ready) acc++;
            if (out_valid) begin
                chk("t3_hold_rob", out_rob_id, 5'd10);
                chk("t3_hold_val", out_value, 32'd50);
            end
            step();
        end
        in_valid = 1'b0;
        chk("t3_stalled_valid", out_valid, 1);
        out_ready = 1'b1;
        exp_rob = 10;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) begin
                chk("t3_drain_rob", out_rob_id, 64'(exp_rob));
                chk("t3_drain_val", out_value, 64'(exp_rob * 5));
                exp_rob++;
            end
            step();
        end
        chk("t3_drain_count", 64'(exp_rob - 10), 64'(acc));

        // Bubble collapse: A, gap, B; stall A one cycle
        put(2'b00, 32'd6, 32'd7, 5'd20);
        step();
        in_valid = 1'b0;
        step();
        put(2'b00, 32'd8, 32'd9, 5'd21);
        step();
        in_valid = 1'b0;
        chk("t4_a_valid", out_valid, 1);
        chk("t4_a_rob", out_rob_id, 5'd20);
        out_ready = 1'b0;
        step();
        chk("t4_a_hold_rob", out_rob_id, 5'd20);
        chk("t4_a_hold_val", out_value, 32'd42);
        out_ready = 1'b1;
        step();
        chk("t4_b_valid", out_valid, 1);
        chk("t4_b_rob", out_rob_id, 5'd21);
        chk("t4_b_val", out_value, 32'd72);
        step();
        chk("t4_drained", out_valid, 0);

        // Flush with in_valid in the flush cycle
        put(2'b00, 32'd2, 32'd3, 5'd1);
        step();
        put(2'b00, 32'd4, 32'd5, 5'd2);
        step();
        put(2'b00, 32'd6, 32'd7, 5'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) nv++;
            step();
        end
        chk("t5_flush_quiet", nv, 0);
        put(2'b11, 32'h0001_0000, 32'h0001_0000, 5'd7);
        step();
        in_valid = 1'b0;
        wait_lat(lat);
        chk("t5_latency", lat, S);
        chk("t5_rob", out_rob_id, 5'd7);
        chk("t5_value", out_value, 32'd1);
        step();

        // Async reset mid-cycle with ops in flight
        out_ready = 1'b0;
        put(2'b00, 32'd3, 32'd3, 5'd8);
        step();
        put(2'b00, 32'd4, 32'd4, 5'd9);
        step();
        in_valid = 1'b0;
        step();
        chk("t6_pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_value", out_value, 0);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid) nv++;
        end
        chk("t6_quiet", nv, 0);
        put(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11);
        step();
        in_valid = 1'b0;
        wait_lat(lat);
        chk("t6_latency", lat, S);
        chk("t6_rob", out_rob_id, 5'd11);
        chk("t6_value", out_value, 32'd1);
`ifdef FU_MUL_DBG_EN
        chk("t6_rs2_dbg", out_rs2_dbg, 32'hFFFF_FFFF);
`endif
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
